mult_div_seq: RTL and testbench
===============================

# mult_div_seq

Sequential multiply/divide unit for the multicycle MIPS datapath, the parametrised successor of the combinational-style MULT/DIV block. It executes MULT, MULTU, DIV and DIVU over `WIDTH`-bit operands in one iteration per clock and writes the double-width result into the HI/LO registers it owns. A start/busy/done handshake lets the control FSM stall on the result instead of assuming a fixed cycle count. Divide-by-zero is flagged rather than computed.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `op` input 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a` input WIDTH: multiplicand / dividend; sampled with `start`.
- `b` input WIDTH: multiplier / divisor; sampled with `start`.
- `busy` output 1: high from the acceptance edge until the edge that raises `done`.
- `done` output 1: one-cycle pulse; `hi`/`lo`/`div0` are valid in the same cycle.
- `hi` output WIDTH: product upper half, or remainder.
- `lo` output WIDTH: product lower half, or quotient.
- `div0` output 1: divide-by-zero flag.

## Operation
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div0`=0, iteration counter 0.
- States:
  - IDLE: `start`=1 latches `a`, `b`, `op`; clears `div0`; sets `busy`.
    - Division with `b`==0 goes to FINISH.
    - Any other accepted request goes to RUN with counter 0.
  - RUN: performs one iteration per edge. Transitions to FINISH after iteration `WIDTH`-1.
  - FINISH: applies the sign fix-up, writes `hi`/`lo`, pulses `done`, clears `busy`, and returns to IDLE.
- MULT: radix-2 Booth. Uses a 2·`WIDTH`+1 product register {upper, multiplier, q-1}.
  - Pair 01: add the multiplicand to the upper half.
  - Pair 10: subtract it.
  - Then arithmetic shift right by 1.
- MULTU: add-shift. Uses a `WIDTH`+1-bit upper accumulator (carry kept) and a logical shift.
- DIV/DIVU: restoring division on magnitudes.
  - Signed operands are converted to absolute values, treated as unsigned `WIDTH`-bit.
  - Each iteration shifts {rem, quo} left, trial-subtracts the divisor, and keeps the result if it is non-negative (quotient bit 1).
- Signed division fix-up in FINISH:
  - Quotient is negated when the operand signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - `lo`=quotient, `hi`=remainder.
  - Most-negative / -1 yields `lo`=most-negative value, `hi`=0, with no flag.
- Divide by zero: `div0`=1 and `hi`/`lo` keep their previous values. `div0` holds until the next accepted `start`.
- `start` while `busy`: ignored, with no effect on the operation in flight.
- `hi`/`lo` change only in FINISH of a non-div0 operation; they hold between operations.
- `reset_n` low mid-operation aborts immediately to reset values. No partial result is written.

## Timing
- Acceptance edge E0; iterations on edges E1…E`WIDTH`; FINISH edge E`WIDTH`+1.
- `done`=1 for the cycle following E`WIDTH`+1 (33 cycles after acceptance for `WIDTH`=32). The same latency applies to all four ops.
- Divide-by-zero: FINISH on E1; `done`=1 and `div0`=1 in the following cycle.
- `start` may be reasserted in the cycle `done` is high (state is IDLE) and is accepted on that edge: back-to-back throughput of one op per `WIDTH`+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `mult_div_pkg`: the `op` encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum (IDLE, RUN, FINISH).
- One sub-module, `md_step`: the combinational single-iteration datapath. It takes the op, the working registers and the operand, and returns the next working registers.
- The FSM, counter, fix-up and output registers stay in `mult_div_seq`.

## Test plan
- MULT with `a`=0xFFFFFFFD (-3), `b`=7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `done` exactly 33 cycles after acceptance; `busy` low in the `done` cycle.
- MULTU with `a`=`b`=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. Then MULT with the same operands -> `hi`=0, `lo`=1.
- DIV -7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100/7 -> `lo`=14, `hi`=2. DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIV 5/0 after a prior result of `hi`=2, `lo`=14 -> `done` 1 cycle after acceptance, `div0`=1, `hi`/`lo` unchanged. The next accepted `start` clears `div0`.
- `start` pulsed at cycle 10 of a MULT with different operands -> ignored; the result matches the original operands.
- Start a new op in the `done` cycle -> accepted, with correct latency.
- `reset_n` low at cycle 15 of a DIVU -> all outputs 0 asynchronously, state IDLE. A subsequent MULT 6×7 -> `lo`=42, `hi`=0.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared encodings for the sequential multiply/divide unit: op codes and FSM states.
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/md_step.sv
// One combinational iteration of the mult/div datapath: Booth (MULT), add-shift (MULTU)
// or restoring division step (DIV/DIVU) over the {acc, low, qm1} working registers.
module md_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       i_op,
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_low,
  input  logic             i_qm1,
  input  logic [WIDTH-1:0] i_mcand,
  output logic [WIDTH:0]   o_acc_next,
  output logic [WIDTH-1:0] o_low_next,
  output logic             o_qm1_next
);

  logic [WIDTH:0] w_mcand_sx;
  logic [WIDTH:0] w_booth_sum;
  logic [WIDTH:0] w_mulu_sum;
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  // Booth keeps a sign-extended upper half so subtracting the most-negative multiplicand cannot overflow.
  assign w_mcand_sx  = {i_mcand[WIDTH-1], i_mcand};
  assign w_booth_sum = (i_low[0] && !i_qm1) ? (i_acc - w_mcand_sx) :
                       (!i_low[0] && i_qm1) ? (i_acc + w_mcand_sx) : i_acc;
  assign w_mulu_sum  = i_low[0] ? ({1'b0, i_acc[WIDTH-1:0]} + {1'b0, i_mcand})
                                : {1'b0, i_acc[WIDTH-1:0]};
  assign w_shifted   = {i_acc[WIDTH-1:0], i_low[WIDTH-1]};
  assign w_trial     = w_shifted - {1'b0, i_mcand};

  always_comb begin
    o_acc_next = i_acc;
    o_low_next = i_low;
    o_qm1_next = i_qm1;
    case (i_op)
      OP_MULT: begin
        o_acc_next = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
        o_low_next = {w_booth_sum[0], i_low[WIDTH-1:1]};
        o_qm1_next = i_low[0];
      end
      OP_MULTU: begin
        o_acc_next = {1'b0, w_mulu_sum[WIDTH:1]};
        o_low_next = {w_mulu_sum[0], i_low[WIDTH-1:1]};
      end
      default: begin
        if (!w_trial[WIDTH]) begin
          o_acc_next = w_trial;
          o_low_next = {i_low[WIDTH-2:0], 1'b1};
        end else begin
          o_acc_next = w_shifted;
          o_low_next = {i_low[WIDTH-2:0], 1'b0};
        end
      end
    endcase
  end

endmodule

// File: rtl/mult_div_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit owning HI/LO; one iteration per clock with a
// start/busy/done handshake and a divide-by-zero flag.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_op;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_low;
  logic             r_qm1;
  logic [WIDTH-1:0] r_mcand;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0_pend;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div0;

  logic             w_is_div;
  logic             w_b_zero;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_acc_next;
  logic [WIDTH-1:0] w_low_next;
  logic             w_qm1_next;

  assign w_is_div = op[1];
  assign w_b_zero = (b == '0);
  assign w_a_neg  = (op == OP_DIV) && a[WIDTH-1];
  assign w_b_neg  = (op == OP_DIV) && b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  md_step #(.WIDTH(WIDTH)) u_step (
    .i_op       (r_op),
    .i_acc      (r_acc),
    .i_low      (r_low),
    .i_qm1      (r_qm1),
    .i_mcand    (r_mcand),
    .o_acc_next (w_acc_next),
    .o_low_next (w_low_next),
    .o_qm1_next (w_qm1_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = (w_is_div && w_b_zero) ? FINISH : RUN;
      RUN:     if (r_cnt == CW'(WIDTH - 1)) w_state_next = FINISH;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op        <= '0;
      r_acc       <= '0;
      r_low       <= '0;
      r_qm1       <= 1'b0;
      r_mcand     <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div0_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_div0      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op        <= op;
            r_acc       <= '0;
            r_qm1       <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_div0      <= 1'b0;
            r_div0_pend <= w_is_div && w_b_zero;
            r_neg_q     <= w_a_neg ^ w_b_neg;
            r_neg_r     <= w_a_neg;
            // Division iterates on magnitudes; multiplication keeps the raw operands.
            r_low       <= w_is_div ? w_a_mag : b;
            r_mcand     <= w_is_div ? w_b_mag : a;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_low <= w_low_next;
          r_qm1 <= w_qm1_next;
          r_cnt <= r_cnt + 1'b1;
        end
        FINISH: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_div0_pend) begin
            r_div0 <= 1'b1;
          end else if (r_op[1]) begin
            r_lo <= r_neg_q ? -r_low : r_low;
            r_hi <= r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
          end else begin
            r_hi <= r_acc[WIDTH-1:0];
            r_lo <= r_low;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign div0 = r_div0;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: arithmetic reference model, per-cycle compare, directed and random ops.
module tb_mult_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div0;

  int checks = 0;
  int errors = 0;

  mult_div_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .div0    (div0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } res_t;

  // Plain-arithmetic reference for one operation.
  function automatic res_t calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    logic [63:0] p;
    longint      sx, sy, q, m;
    r = '0;
    case (o)
      2'b00: begin
        p = 64'(longint'($signed(x)) * longint'($signed(y)));
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, x} * {32'b0, y};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          r.dz = 1'b1;
        end else begin
          if (o == 2'b10) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
          end else begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
          end
          q = sx / sy;
          m = sx % sy;
          r.lo = q[31:0];
          r.hi = m[31:0];
        end
      end
    endcase
    return r;
  endfunction

  // Behavioural model: latency-based view of the unit.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_div0 = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_cnt = 0;
  logic [1:0]  m_op = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  res_t        p_res = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_div0 <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          if (p_res.dz) m_div0 <= 1'b1;
          else begin
            m_hi <= p_res.hi;
            m_lo <= p_res.lo;
          end
        end
      end else if (start) begin
        m_op   <= op;
        m_a    <= a;
        m_b    <= b;
        p_res  <= calc(op, a, b);
        m_busy <= 1'b1;
        m_div0 <= 1'b0;
        m_cnt  <= (op[1] && b == 32'd0) ? 1 : W + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("hi",   64'(hi),   64'(m_hi));
    check("lo",   64'(lo),   64'(m_lo));
    check("div0", 64'(div0), 64'(m_div0));
    if (m_done)
      $display("txn op=%0d a=%h b=%h -> hi=%h lo=%h div0=%b", m_op, m_a, m_b, hi, lo, div0);
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges after acceptance until done is seen; bounded.
  task automatic wait_done(input int k0, output int lat);
    lat = k0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 100);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d expected=done", lat);
    end
  endtask

  int lat;
  int sel;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    check("rst_div0", 64'(div0), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'hFFFFFFFD, 32'd7);
    wait_done(0, lat);
    check("mult_lat",  64'(lat),  64'd33);
    check("mult_hi",   64'(hi),   64'hFFFFFFFF);
    check("mult_lo",   64'(lo),   64'hFFFFFFEB);
    check("mult_busy", 64'(busy), 64'd0);
    @(negedge clk);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, lat);
    check("multu_hi", 64'(hi), 64'hFFFFFFFE);
    check("multu_lo", 64'(lo), 64'h00000001);
    @(negedge clk);
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, lat);
    check("mult_m1_hi", 64'(hi), 64'h0);
    check("mult_m1_lo", 64'(lo), 64'h1);
    @(negedge clk);

    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(0, lat);
    check("div_lat", 64'(lat), 64'd33);
    check("div_lo",  64'(lo),  64'hFFFFFFFD);
    check("div_hi",  64'(hi),  64'hFFFFFFFF);
    @(negedge clk);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0, lat);
    check("divmn_lo",   64'(lo),   64'h80000000);
    check("divmn_hi",   64'(hi),   64'h0);
    check("divmn_div0", 64'(div0), 64'd0);
    @(negedge clk);
    issue(2'b11, 32'd100, 32'd7);
    wait_done(0, lat);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);
    @(negedge clk);

    issue(2'b10, 32'd5, 32'd0);
    wait_done(0, lat);
    check("dz_lat",  64'(lat),  64'd1);
    check("dz_div0", 64'(div0), 64'd1);
    check("dz_hi",   64'(hi),   64'd2);
    check("dz_lo",   64'(lo),   64'd14);
    @(negedge clk);
    check("dz_hold", 64'(div0), 64'd1);
    issue(2'b00, 32'd3, 32'd5);
    check("dz_clr", 64'(div0), 64'd0);
    wait_done(0, lat);
    check("m35_lo", 64'(lo), 64'd15);
    @(negedge clk);

    issue(2'b00, 32'd1234, 32'd5678);
    repeat (8) @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'hDEADBEEF;
    b     = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    wait_done(9, lat);
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_hi",  64'(hi),  64'd0);
    check("ign_lo",  64'(lo),  64'h006AE9BC);

    issue(2'b01, 32'h00010000, 32'h00010000);
    wait_done(0, lat);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_hi",  64'(hi),  64'd1);
    check("b2b_lo",  64'(lo),  64'd0);
    @(negedge clk);

    issue(2'b11, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi",   64'(hi),   64'd0);
    check("arst_lo",   64'(lo),   64'd0);
    check("arst_div0", 64'(div0), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 32'd6, 32'd7);
    wait_done(0, lat);
    check("post_rst_lo", 64'(lo), 64'd42);
    check("post_rst_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      ra  = (sel == 0) ? 32'h80000000 : $urandom;
      sel = $urandom_range(0, 9);
      rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFFFFFF :
            (sel == 2) ? 32'h80000000 : (sel == 3) ? 32'd1 : $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ro, ra, rb);
      wait_done(0, lat);
      check("rnd_lat", 64'(lat), (ro[1] && rb == 32'd0) ? 64'd1 : 64'd33);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
